// File: rtl/core_seq_pkg.sv
// Shared opcode, state and decode-flag definitions for the core sequencer.
package core_seq_pkg;

  typedef enum logic [4:0] {
    OPC_SETDR = 5'h00, OPC_ADD  = 5'h01, OPC_SUB  = 5'h02, OPC_AND  = 5'h03,
    OPC_OR    = 5'h04, OPC_XOR  = 5'h05, OPC_LD   = 5'h06, OPC_LDI  = 5'h07,
    OPC_ST    = 5'h08, OPC_STI  = 5'h09, OPC_SHL  = 5'h0A, OPC_SHR  = 5'h0B,
    OPC_INC   = 5'h0C, OPC_DEC  = 5'h0D, OPC_NOT  = 5'h0E, OPC_MOV  = 5'h0F,
    OPC_ADC   = 5'h10, OPC_SBC  = 5'h11, OPC_ROL  = 5'h12, OPC_ROR  = 5'h13,
    OPC_CMPI  = 5'h14, OPC_CMPR = 5'h15, OPC_JMP  = 5'h16, OPC_JZ   = 5'h17,
    OPC_JFNZ  = 5'h18, OPC_JNZ  = 5'h19, OPC_NEG  = 5'h1A, OPC_SWAP = 5'h1B,
    OPC_CLR   = 5'h1C, OPC_SET  = 5'h1D, OPC_NOP  = 5'h1E, OPC_HALT = 5'h1F
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [4:0] OP_HALT  = 5'h1F;
  localparam logic [4:0] OP_CMP_I = 5'h14;
  localparam logic [4:0] OP_CMP_R = 5'h15;
  localparam logic [4:0] OP_SETDR = 5'h00;

  typedef struct packed {
    logic is_alu;
    logic is_wb;
    logic is_load;
    logic is_store;
    logic is_jump;
    logic is_halt;
  } op_flags_t;

endpackage

// File: rtl/core_seq_op_class.sv
// Combinational opcode classifier: maps the 5-bit opcode onto phase-routing flags.
module core_seq_op_class
  import core_seq_pkg::*;
(
  input  logic [4:0] op,
  output op_flags_t  flags
);

  logic ld, st, jmp, hlt, alu;

  always_comb begin
    ld  = (op == OPC_LD)  || (op == OPC_LDI);
    st  = (op == OPC_ST)  || (op == OPC_STI);
    jmp = (op == OPC_JMP) || (op == OPC_JZ) || (op == OPC_JNZ) || (op == OPC_JFNZ);
    hlt = (op == OP_HALT);
    alu = !(ld || st || jmp || hlt);

    flags          = '0;
    flags.is_load  = ld;
    flags.is_store = st;
    flags.is_jump  = jmp;
    flags.is_halt  = hlt;
    flags.is_alu   = alu;
    // compares and setdr only update flags / the dr pointer, never a register
    flags.is_wb    = ld || (alu && (op != OP_CMP_I) && (op != OP_CMP_R) && (op != OP_SETDR));
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/writeback with jump resolution.
// Owns pc and the reg_file write port; memory phase waits indefinitely on mem_ready.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr_in,
  input  logic [3:0]       dr_code,
  input  logic [7:0]       addr_base,
  input  logic             zero,
  input  logic             fb,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [4:0]       rf_instr,
  output logic [3:0]       rf_oprnd,
  output logic             rf_write_en,
  output logic [3:0]       rf_waddr,
  output logic             alu_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] FETCH  = S_FETCH;
  localparam logic [2:0] DECODE = S_DECODE;
  localparam logic [2:0] EXEC   = S_EXEC;
  localparam logic [2:0] MEM    = S_MEM;
  localparam logic [2:0] WB     = S_WB;
  localparam logic [2:0] HALT   = S_HALT;

  logic [2:0]       state, state_nxt;
  logic [8:0]       ir;
  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc, pc_tgt;
  logic [CNT_W-1:0] retired_q;
  logic             retire, taken;
  op_flags_t        flags;

  core_seq_op_class u_op_class (
    .op    (ir[8:4]),
    .flags (flags)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = PC_W'(addr_base) + PC_W'(ir[3:0]);

  always_comb begin
    taken = 1'b0;
    case (ir[8:4])
      OPC_JMP:  taken = 1'b1;
      OPC_JZ:   taken = zero;
      OPC_JNZ:  taken = !zero;
      OPC_JFNZ: taken = !fb;
      default:  taken = 1'b0;
    endcase
  end

  // retire marks the last phase of an instruction; pc advance rides with it
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    retire    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
        end
      end
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (flags.is_halt) begin
          state_nxt = HALT;
          retire    = 1'b1;
        end else if (flags.is_load || flags.is_store) begin
          state_nxt = MEM;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (flags.is_jump) begin
          state_nxt = FETCH;
          pc_nxt    = taken ? pc_tgt : pc_inc;
          retire    = 1'b1;
        end else if (flags.is_wb) begin
          state_nxt = WB;
        end else begin
          state_nxt = FETCH;
          pc_nxt    = pc_inc;
          retire    = 1'b1;
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (flags.is_load) begin
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = pc_inc;
            retire    = 1'b1;
          end
        end
      end
      WB: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        retire    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      ir        <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (state == FETCH) ir <= instr_in;
      if (retire && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc          = pc_q;
  assign rf_instr    = ir[8:4];
  assign rf_oprnd    = ir[3:0];
  assign rf_write_en = (state == WB);
  assign rf_waddr    = (state == WB) ? dr_code : 4'h0;
  assign alu_en      = (state == EXEC) && flags.is_alu;
  assign mem_req     = (state == MEM);
  assign mem_we      = (state == MEM) && flags.is_store;
  assign busy        = (state != IDLE) && (state != HALT);
  assign halted      = (state == HALT);
  assign retired     = retired_q;

endmodule

// File: tb/tb_core_seq.sv
// Scenario bench for core_seq: scoreboard of expected writeback addresses per program.
module tb_core_seq;
  import core_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, zero, fb, mem_ready;
  logic [3:0]  dr_code;
  logic [7:0]  addr_base;
  logic [8:0]  instr_in, instr_in2;
  logic [7:0]  pc, pc2;
  logic [4:0]  rf_instr, rf_instr2;
  logic [3:0]  rf_oprnd, rf_oprnd2, rf_waddr, rf_waddr2;
  logic        rf_write_en, alu_en, mem_req, mem_we, busy, halted;
  logic        rf_write_en2, alu_en2, mem_req2, mem_we2, busy2, halted2;
  logic [15:0] retired;
  logic [3:0]  retired2;
  logic [4:0]  oc_op;
  op_flags_t   oc_flags;

  logic [8:0]  rom [256];
  logic [3:0]  exp_waddr [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign instr_in  = rom[pc];
  assign instr_in2 = rom[pc2];

  core_seq #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in), .dr_code(dr_code),
    .addr_base(addr_base), .zero(zero), .fb(fb), .mem_ready(mem_ready), .pc(pc),
    .rf_instr(rf_instr), .rf_oprnd(rf_oprnd), .rf_write_en(rf_write_en), .rf_waddr(rf_waddr),
    .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .halted(halted),
    .retired(retired)
  );

  core_seq #(.PC_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in2), .dr_code(dr_code),
    .addr_base(addr_base), .zero(zero), .fb(fb), .mem_ready(mem_ready), .pc(pc2),
    .rf_instr(rf_instr2), .rf_oprnd(rf_oprnd2), .rf_write_en(rf_write_en2), .rf_waddr(rf_waddr2),
    .alu_en(alu_en2), .mem_req(mem_req2), .mem_we(mem_we2), .busy(busy2), .halted(halted2),
    .retired(retired2)
  );

  core_seq_op_class u_oc (.op(oc_op), .flags(oc_flags));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_fill(input logic [8:0] val);
    for (int i = 0; i < 256; i++) rom[i] = val;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_waddr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_checks++; if (retired !== 16'h0) begin n_fail++; $display("FAIL reset_retired: got %h want 0", retired); end
    n_checks++; if ({rf_write_en, alu_en, mem_req, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {rf_write_en, alu_en, mem_req, mem_we}); end
    n_checks++; if ({busy, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {busy, halted}); end
    n_checks++; if ({rf_instr, rf_oprnd} !== 9'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 000", {rf_instr, rf_oprnd}); end
    n_checks++; if (retired2 !== 4'h0) begin n_fail++; $display("FAIL reset_retired_sat: got %h want 0", retired2); end
    reset = 1'b0;
  endtask

  task automatic test_op_class();
    for (int i = 0; i < 32; i++) begin
      logic [5:0] want;
      logic ld, st, jp, ht, al;
      oc_op = 5'(i);
      #1;
      ld = (i == 6) || (i == 7);
      st = (i == 8) || (i == 9);
      jp = (i >= 'h16) && (i <= 'h19);
      ht = (i == 'h1F);
      al = !(ld || st || jp || ht);
      want = {al, ld || (al && i != 0 && i != 'h14 && i != 'h15), ld, st, jp, ht};
      n_checks++;
      if (oc_flags !== want) begin
        n_fail++; $display("FAIL op_class op=%h: got %b want %b", i[4:0], oc_flags, want);
      end
    end
  endtask

  task automatic test_alu_wb();
    do_reset();
    rom_fill(9'h1FF); rom[0] = 9'h01E; dr_code = 4'h0;
    // abort a run partway, then restart cleanly
    start = 1'b1; tick(); start = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || rf_write_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%b we=%b want 0 0", busy, rf_write_en); end
    exp_waddr.push_back(4'h0);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick(); start = 1'b0;
      n_checks++;
      if (rf_write_en !== (c == 4)) begin n_fail++; $display("FAIL add_we c%0d: got %b want %b", c, rf_write_en, c == 4); end
      if (rf_write_en) begin
        n_checks++;
        if (exp_waddr.size() == 0) begin n_fail++; $display("FAIL add_waddr: got unexpected write to %h want none", rf_waddr); end
        else begin
          logic [3:0] e = exp_waddr.pop_front();
          if (rf_waddr !== e) begin n_fail++; $display("FAIL add_waddr: got %h want %h", rf_waddr, e); end
        end
      end
      if (c == 2) begin
        n_checks++; if ({rf_instr, rf_oprnd} !== 9'h01E) begin n_fail++; $display("FAIL add_ir: got %h want 01e", {rf_instr, rf_oprnd}); end
      end
      if (c == 3) begin
        n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL add_alu_en: got %b want 1", alu_en); end
      end
      if (c == 5) begin
        n_checks++; if (pc !== 8'h01 || retired !== 16'd1) begin
          n_fail++; $display("FAIL add_done: got pc=%h ret=%0d want pc=01 ret=1", pc, retired); end
      end
    end
    n_checks++; if (exp_waddr.size() != 0) begin n_fail++; $display("FAIL add_sb_left: got %0d pending want 0", exp_waddr.size()); end
  endtask

  task automatic test_load();
    do_reset();
    rom_fill(9'h1FF); rom[0] = 9'h071; dr_code = 4'h9;
    exp_waddr.push_back(4'h9);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(); start = 1'b0; mem_ready = (c == 6);
      n_checks++;
      if (mem_req !== (c >= 3 && c <= 6) || (mem_req && mem_we !== 1'b0)) begin
        n_fail++; $display("FAIL load_mem c%0d: got req=%b we=%b want req=%b we=0", c, mem_req, mem_we, (c >= 3 && c <= 6)); end
      n_checks++;
      if (rf_write_en !== (c == 7)) begin n_fail++; $display("FAIL load_we c%0d: got %b want %b", c, rf_write_en, c == 7); end
      if (rf_write_en && exp_waddr.size() > 0) begin
        logic [3:0] e = exp_waddr.pop_front();
        n_checks++;
        if (rf_waddr !== e) begin n_fail++; $display("FAIL load_waddr: got %h want %h", rf_waddr, e); end
      end
      if (c == 8) begin
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL load_pc: got %h want 01", pc); end
      end
    end
    mem_ready = 1'b0;
    n_checks++; if (exp_waddr.size() != 0) begin n_fail++; $display("FAIL load_sb_left: got %0d pending want 0", exp_waddr.size()); end

    // reset lands in the second MEM cycle
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(); start = 1'b0;
      reset = (c == 4);
      n_checks++;
      if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL load_rst_we c%0d: got %b want 0", c, rf_write_en); end
      if (c == 5) begin
        n_checks++; if ({mem_req, busy, halted} !== 3'b000) begin
          n_fail++; $display("FAIL load_rst_idle: got req/busy/halt=%b want 000", {mem_req, busy, halted}); end
      end
    end
  endtask

  task automatic test_jumps();
    logic [8:0] j_ins  [8] = '{9'h164, 9'h177, 9'h164, 9'h177, 9'h193, 9'h193, 9'h185, 9'h185};
    logic [7:0] j_base [8] = '{8'h41,  8'h41,  8'hFE,  8'h10,  8'h20,  8'h20,  8'h30,  8'h30};
    logic       j_zero [8] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    logic       j_fb   [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
    logic [7:0] j_exp  [8] = '{8'h45,  8'h01,  8'h02,  8'h17,  8'h23,  8'h01,  8'h35,  8'h01};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      rom_fill(9'h1FF); rom[0] = j_ins[k];
      addr_base = j_base[k]; zero = j_zero[k]; fb = j_fb[k];
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick(); start = 1'b0;
        n_checks++;
        if (rf_write_en !== 1'b0 || mem_req !== 1'b0) begin
          n_fail++; $display("FAIL jump%0d_strobe c%0d: got we=%b req=%b want 0 0", k, c, rf_write_en, mem_req); end
        if (c == 4) begin
          n_checks++; if (pc !== j_exp[k] || retired !== 16'd1) begin
            n_fail++; $display("FAIL jump%0d_pc: got pc=%h ret=%0d want pc=%h ret=1", k, pc, retired, j_exp[k]); end
        end
      end
    end
    zero = 1'b0; fb = 1'b0;
  endtask

  task automatic test_cmp_halt();
    do_reset();
    rom_fill(9'h1FF); rom[0] = 9'h152; rom[1] = 9'h1FF;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick(); start = 1'b0;
      n_checks++;
      if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL cmp_we c%0d: got %b want 0", c, rf_write_en); end
      if (c == 3) begin
        n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL cmp_alu_en: got %b want 1", alu_en); end
      end
    end
    n_checks++; if ({halted, busy} !== 2'b10 || retired !== 16'd2) begin
      n_fail++; $display("FAIL halt_state: got halt/busy=%b ret=%0d want 10 ret=2", {halted, busy}, retired); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (pc !== 8'h00 || halted !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart: got pc=%h halt=%b busy=%b want 00 0 1", pc, halted, busy); end
  endtask

  task automatic test_wrap_saturate();
    bit seen_ff = 0, done = 0;
    do_reset();
    rom_fill(9'h014); dr_code = 4'h4;
    for (int i = 0; i < 256; i++) exp_waddr.push_back(4'h4);
    start = 1'b1;
    for (int c = 1; c <= 1200 && !done; c++) begin
      tick(); start = 1'b0;
      if (rf_write_en) begin
        n_checks++;
        if (exp_waddr.size() == 0) begin n_fail++; $display("FAIL wrap_waddr: got extra write to %h want none", rf_waddr); end
        else begin
          logic [3:0] e = exp_waddr.pop_front();
          if (rf_waddr !== e) begin n_fail++; $display("FAIL wrap_waddr: got %h want %h", rf_waddr, e); end
        end
      end
      if (retired == 16'd255 && !seen_ff) begin
        seen_ff = 1;
        n_checks++; if (pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_pc_ff: got %h want ff", pc); end
      end
      if (retired == 16'd256) begin
        done = 1;
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_00: got %h want 00", pc); end
        n_checks++; if (retired2 !== 4'hF) begin n_fail++; $display("FAIL sat_retired: got %h want f", retired2); end
        n_checks++; if (exp_waddr.size() != 0) begin n_fail++; $display("FAIL wrap_sb_left: got %0d want 0", exp_waddr.size()); end
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL wrap_timeout: got retired=%0d want 256 within budget", retired);
    end
  endtask

  task automatic test_store();
    int reqs = 0;
    do_reset();
    rom_fill(9'h1FF); rom[0] = 9'h084; mem_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick(); start = 1'b0;
      if (mem_req) begin
        reqs++;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", mem_we); end
      end
      n_checks++;
      if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL store_rf_we c%0d: got %b want 0", c, rf_write_en); end
      if (c == 4) begin
        n_checks++; if (pc !== 8'h01 || busy !== 1'b1) begin
          n_fail++; $display("FAIL store_next: got pc=%h busy=%b want 01 1", pc, busy); end
      end
    end
    n_checks++; if (reqs != 1) begin n_fail++; $display("FAIL store_req_len: got %0d want 1", reqs); end
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; fb = 1'b0;
    dr_code = 4'h0; addr_base = 8'h00; oc_op = 5'h0;
    rom_fill(9'h1FF);
    test_reset();
    test_op_class();
    test_alu_wb();
    test_load();
    test_jumps();
    test_cmp_halt();
    test_store();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
